// File: rtl/multi_digit_lock.sv
// Keypad lock: buffers a multi-digit entry, compares on enter, counts failures and enforces a timed lockout.
// Optional AUTO_RELOCK_EN macro adds an idle timer that relocks after RELOCK_CYCLES quiet cycles in UNLOCKED.
module multi_digit_lock #(
  parameter int unsigned DIGIT_W        = 4,
  parameter int unsigned CODE_LEN       = 4,
  parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = 16'h1A2B,
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 1000,
  parameter int unsigned RELOCK_CYCLES  = 5000
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              digit_valid,
  input  logic [DIGIT_W-1:0]                digit,
  input  logic                              enter,
  input  logic                              clear,
  input  logic                              lock,
  input  logic                              set_code,
  output logic                              unlocked,
  output logic                              wrong_code,
  output logic                              code_set,
  output logic                              locked_out,
  output logic [$clog2(CODE_LEN+1)-1:0]     digit_count,
  output logic [$clog2(MAX_TRIES+1)-1:0]    tries_left
);

  localparam int unsigned CODE_W = CODE_LEN * DIGIT_W;
  localparam int unsigned CNT_W  = $clog2(CODE_LEN + 1);
  localparam int unsigned TRY_W  = $clog2(MAX_TRIES + 1);
  localparam int unsigned TMR_W  = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'd0,
    ST_UNLOCKED = 2'd1,
    ST_LOCKOUT  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CODE_W-1:0]  buf_q, buf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CODE_W-1:0]  code_q, code_d;
  logic [TRY_W-1:0]   tries_q, tries_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               wrong_q, wrong_d;
  logic               set_q, set_d;
  logic               unl_q, lo_q;

  logic               ctrl_c;
  logic               full_c;
  logic               dig_ok_c;
  logic [CODE_W-1:0]  buf_shift_c;

`ifdef AUTO_RELOCK_EN
  localparam int unsigned IDLE_W = (RELOCK_CYCLES > 1) ? $clog2(RELOCK_CYCLES) : 1;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic               act_c;
  assign act_c = digit_valid | set_code | clear | lock;
`endif

  // Any control strobe outranks a digit arriving in the same cycle.
  assign ctrl_c      = clear | enter | lock | set_code;
  assign full_c      = (cnt_q == CNT_W'(CODE_LEN));
  assign dig_ok_c    = digit_valid && !ctrl_c && !full_c;
  assign buf_shift_c = (buf_q << DIGIT_W) | CODE_W'(digit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_LOCKED;
      buf_q   <= '0;
      cnt_q   <= '0;
      code_q  <= DEFAULT_CODE;
      tries_q <= TRY_W'(MAX_TRIES);
      timer_q <= '0;
      wrong_q <= 1'b0;
      set_q   <= 1'b0;
      unl_q   <= 1'b0;
      lo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      tries_q <= tries_d;
      timer_q <= timer_d;
      wrong_q <= wrong_d;
      set_q   <= set_d;
      unl_q   <= (state_d == ST_UNLOCKED);
      lo_q    <= (state_d == ST_LOCKOUT);
    end
  end

`ifdef AUTO_RELOCK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) idle_q <= '0;
    else       idle_q <= idle_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    tries_d = tries_q;
    timer_d = timer_q;
    wrong_d = 1'b0;
    set_d   = 1'b0;
`ifdef AUTO_RELOCK_EN
    idle_d  = '0;
`endif
    unique case (state_q)
      ST_LOCKED: begin
        if (clear) begin
          buf_d = '0;
          cnt_d = '0;
        end else if (enter) begin
          buf_d = '0;
          cnt_d = '0;
          if (full_c && (buf_q == code_q)) begin
            state_d = ST_UNLOCKED;
            tries_d = TRY_W'(MAX_TRIES);
          end else begin
            wrong_d = 1'b1;
            if (tries_q <= TRY_W'(1)) begin
              state_d = ST_LOCKOUT;
              tries_d = '0;
              timer_d = TMR_W'(LOCKOUT_CYCLES - 1);
            end else begin
              tries_d = tries_q - TRY_W'(1);
            end
          end
        end else if (dig_ok_c) begin
          buf_d = buf_shift_c;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_UNLOCKED: begin
        if (clear) begin
          buf_d = '0;
          cnt_d = '0;
        end else if (lock) begin
          state_d = ST_LOCKED;
          buf_d   = '0;
          cnt_d   = '0;
        end else if (set_code && full_c) begin
          code_d = buf_q;
          set_d  = 1'b1;
          buf_d  = '0;
          cnt_d  = '0;
        end else if (dig_ok_c) begin
          buf_d = buf_shift_c;
          cnt_d = cnt_q + CNT_W'(1);
        end
`ifdef AUTO_RELOCK_EN
        // Quiet cycles accumulate; an enter alone does not count as activity.
        if (!act_c) begin
          if (idle_q == IDLE_W'(RELOCK_CYCLES - 1)) begin
            state_d = ST_LOCKED;
            buf_d   = '0;
            cnt_d   = '0;
          end else begin
            idle_d = idle_q + IDLE_W'(1);
          end
        end
`endif
      end
      ST_LOCKOUT: begin
        buf_d = '0;
        cnt_d = '0;
        if (timer_q == '0) begin
          state_d = ST_LOCKED;
          tries_d = TRY_W'(MAX_TRIES);
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      default: begin
        state_d = ST_LOCKED;
        buf_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  assign unlocked    = unl_q;
  assign wrong_code  = wrong_q;
  assign code_set    = set_q;
  assign locked_out  = lo_q;
  assign digit_count = cnt_q;
  assign tries_left  = tries_q;

endmodule

// File: tb/tb_multi_digit_lock.sv
// Scoreboard bench for multi_digit_lock: a digit-queue reference model predicts every cycle's outputs.
module tb_multi_digit_lock;

  localparam int CL      = 4;
  localparam int MAXT    = 3;
  localparam int LOCKOUT = 1000;
  localparam int RELOCK  = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       digit_valid = 1'b0;
  logic [3:0] digit = '0;
  logic       enter = 1'b0, clear = 1'b0, lock = 1'b0, set_code = 1'b0;
  logic       unlocked, wrong_code, code_set, locked_out;
  logic [2:0] digit_count;
  logic [1:0] tries_left;

  multi_digit_lock #(
    .DIGIT_W(4), .CODE_LEN(CL), .DEFAULT_CODE(16'h1A2B),
    .MAX_TRIES(MAXT), .LOCKOUT_CYCLES(LOCKOUT), .RELOCK_CYCLES(RELOCK)
  ) dut (
    .clk(clk), .reset(reset), .digit_valid(digit_valid), .digit(digit),
    .enter(enter), .clear(clear), .lock(lock), .set_code(set_code),
    .unlocked(unlocked), .wrong_code(wrong_code), .code_set(code_set),
    .locked_out(locked_out), .digit_count(digit_count), .tries_left(tries_left)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unl; int wc; int cs; int lo; int cnt; int tries;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Reference model: mode 0=locked, 1=unlocked, 2=lockout
  int   m_mode, m_tries, m_lo, m_idle;
  int   m_q[$];
  int   m_code[CL];

  function automatic void model_reset();
    m_mode = 0; m_tries = MAXT; m_lo = 0; m_idle = 0;
    m_q.delete();
    m_code[0] = 1; m_code[1] = 10; m_code[2] = 2; m_code[3] = 11;
  endfunction

  function automatic bit match_code();
    for (int i = 0; i < CL; i++) if (m_q[i] != m_code[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic exp_t model_step(bit dv, int d, bit en, bit clr, bit lk, bit sc);
    exp_t e;
    int start = m_mode;
    bit act = dv | sc | clr | lk;
    bit ctrl = clr | en | lk | sc;
    e.wc = 0; e.cs = 0;
    if (m_mode == 2) begin
      m_q.delete();
      m_lo--;
      if (m_lo == 0) begin m_mode = 0; m_tries = MAXT; end
    end else if (clr) begin
      m_q.delete();
    end else if (m_mode == 0 && en) begin
      if (m_q.size() == CL && match_code()) begin
        m_mode = 1; m_tries = MAXT; m_idle = 0;
      end else begin
        e.wc = 1;
        m_tries--;
        if (m_tries == 0) begin m_mode = 2; m_lo = LOCKOUT; end
      end
      m_q.delete();
    end else if (m_mode == 1 && lk) begin
      m_mode = 0; m_q.delete();
    end else if (m_mode == 1 && sc && m_q.size() == CL) begin
      for (int i = 0; i < CL; i++) m_code[i] = m_q[i];
      e.cs = 1; m_q.delete();
    end else if (!ctrl && dv && m_q.size() < CL) begin
      m_q.push_back(d);
    end
`ifdef AUTO_RELOCK_EN
    if (start == 1) begin
      if (act) m_idle = 0;
      else begin
        m_idle++;
        if (m_idle == RELOCK) begin m_mode = 0; m_q.delete(); m_idle = 0; end
      end
    end
`else
    if (start == 1 && act) m_idle = 0;
`endif
    e.unl = (m_mode == 1); e.lo = (m_mode == 2);
    e.cnt = m_q.size(); e.tries = m_tries;
    return e;
  endfunction

  task automatic step(bit dv, int d, bit en, bit clr, bit lk, bit sc);
    @(negedge clk);
    reset = 1'b0;
    digit_valid = dv; digit = 4'(d); enter = en; clear = clr; lock = lk; set_code = sc;
    sb.push_back(model_step(dv, d, en, clr, lk, sc));
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic dig(int d);
    step(1, d, 0, 0, 0, 0);
  endtask

  task automatic entry(int d0, int d1, int d2, int d3);
    dig(d0); dig(d1); dig(d2); dig(d3);
    step(0, 0, 1, 0, 0, 0);
  endtask

  task automatic do_reset(int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset = 1'b1;
      digit_valid = 0; enter = 0; clear = 0; lock = 0; set_code = 0;
      model_reset();
      e.unl = 0; e.wc = 0; e.cs = 0; e.lo = 0; e.cnt = 0; e.tries = MAXT;
      sb.push_back(e);
    end
  endtask

  task automatic chk(string nm, int got, int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL cyc=%0d %s got=%0d exp=%0d", cyc, nm, got, expv);
    end
  endtask

  // Monitor: outputs are valid every cycle, so one expected entry is retired per edge
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("unlocked", int'(unlocked), e.unl);
      chk("wrong_code", int'(wrong_code), e.wc);
      chk("code_set", int'(code_set), e.cs);
      chk("locked_out", int'(locked_out), e.lo);
      chk("digit_count", int'(digit_count), e.cnt);
      chk("tries_left", int'(tries_left), e.tries);
    end
  end

  initial begin
    int r, d;
    model_reset();
    do_reset(2);

    entry(1, 10, 2, 11);
    step(0, 0, 0, 0, 1, 0);

    // three failures into lockout, correct code ignored during lockout
    entry(1, 10, 2, 12);
    entry(1, 10, 2, 12);
    entry(1, 10, 2, 12);
    entry(1, 10, 2, 11);
    idle(LOCKOUT);

    // reprogram and verify old code is rejected
    entry(1, 10, 2, 11);
    dig(5); dig(5); dig(5); dig(5);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0);
    entry(1, 10, 2, 11);
    entry(5, 5, 5, 5);
    dig(3); dig(4);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1);

    // reset mid-entry reverts to the default code
    dig(1); dig(2);
    do_reset(1);
    dig(1); dig(10); dig(2); dig(11);
    step(1, 7, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    dig(1); dig(10); dig(2); dig(11); dig(3); dig(4);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    dig(1); dig(10); step(1, 2, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    idle(LOCKOUT);

`ifdef AUTO_RELOCK_EN
    entry(1, 10, 2, 11);
    idle(14);
    dig(3);
    idle(RELOCK + 2);
`endif

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 40) == 0) begin
        entry(m_code[0], m_code[1], m_code[2], m_code[3]);
      end else begin
        r = $urandom_range(0, 99);
        d = ($urandom_range(0, 1) == 1) ? m_code[$urandom_range(0, CL - 1)] : $urandom_range(0, 15);
        if (r < 60)      step(1, d, 0, 0, 0, 0);
        else if (r < 67) step($urandom_range(0, 1), d, 1, 0, 0, 0);
        else if (r < 71) step($urandom_range(0, 1), d, 0, 1, 0, 0);
        else if (r < 75) step($urandom_range(0, 1), d, 0, 0, 1, $urandom_range(0, 1));
        else if (r < 81) step($urandom_range(0, 1), d, 0, 0, 0, 1);
        else             step(0, 0, 0, 0, 0, 0);
      end
    end

    idle(2);
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
